// File: rtl/fifo_stream_reader.sv
// Drain stage for a show-ahead FIFO: pops words and presents them as a valid/ready
// stream through a 2-entry skid buffer, sustaining one word per cycle.
//
// state | meaning
// EMPTY | no buffered word, m_valid_o low
// ONE   | head holds the word on m_data_o
// TWO   | head on m_data_o, tail holds the next word; pops stall
module fifo_stream_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fifo_empty_i,
    input  logic [DATA_WIDTH-1:0] fifo_rdata_i,
    output logic                  fifo_rden_o,
    output logic                  m_valid_o,
    input  logic                  m_ready_i,
    output logic [DATA_WIDTH-1:0] m_data_o,
    input  logic                  flush_i,
    output logic [CNT_WIDTH-1:0]  pop_cnt_o
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] head;
    logic [DATA_WIDTH-1:0] tail;
    logic                  take;

    // The pop decision looks only at registered state, never at m_ready_i, so the
    // downstream ready does not reach the FIFO combinationally.
    assign fifo_rden_o = rst_n & ~fifo_empty_i & ~flush_i & (state != TWO);
    assign m_valid_o   = (state != EMPTY);
    assign m_data_o    = head;
    assign take        = m_valid_o & m_ready_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= EMPTY;
            head      <= '0;
            tail      <= '0;
            pop_cnt_o <= '0;
        end else begin
            if (fifo_rden_o) begin
                pop_cnt_o <= pop_cnt_o + 1'b1;
            end
            if (flush_i) begin
                state <= EMPTY;
            end else begin
                case (state)
                    EMPTY: begin
                        if (fifo_rden_o) begin
                            state <= ONE;
                            head  <= fifo_rdata_i;
                        end
                    end
                    ONE: begin
                        if (fifo_rden_o && take) begin
                            head <= fifo_rdata_i;
                        end else if (fifo_rden_o) begin
                            state <= TWO;
                            tail  <= fifo_rdata_i;
                        end else if (take) begin
                            state <= EMPTY;
                        end
                    end
                    TWO: begin
                        if (take) begin
                            state <= ONE;
                            head  <= tail;
                        end
                    end
                    default: state <= EMPTY;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: behavioural show-ahead FIFO feeding the DUT and a
// scoreboard of popped words compared against every accepted output word.
module tb_fifo_stream_reader;

    localparam int DW = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          fifo_empty_i = 1'b1;
    logic [DW-1:0] fifo_rdata_i = '0;
    logic          fifo_rden_o;
    logic          m_valid_o;
    logic          m_ready_i = 1'b0;
    logic [DW-1:0] m_data_o;
    logic          flush_i = 1'b0;
    logic [CW-1:0] pop_cnt_o;

    logic          gate = 1'b0;
    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] exp_q[$];
    logic [CW-1:0] cnt_exp = '0;
    int            checks = 0;
    int            errors = 0;
    int            pops = 0;

    fifo_stream_reader #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .fifo_empty_i (fifo_empty_i),
        .fifo_rdata_i (fifo_rdata_i),
        .fifo_rden_o  (fifo_rden_o),
        .m_valid_o    (m_valid_o),
        .m_ready_i    (m_ready_i),
        .m_data_o     (m_data_o),
        .flush_i      (flush_i),
        .pop_cnt_o    (pop_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_fifo();
        fifo_empty_i = gate || (fifo_q.size() == 0);
        fifo_rdata_i = (fifo_q.size() != 0) ? fifo_q[0] : '0;
    endtask

    // One clock: sample handshakes before the edge, update model, check after.
    task automatic cycle();
        logic          pop;
        logic          take;
        logic          fl;
        logic [DW-1:0] d;
        drive_fifo();
        #1;
        pop  = fifo_rden_o;
        take = m_valid_o && m_ready_i;
        fl   = flush_i;
        d    = m_data_o;
        check("valid_vs_model", m_valid_o, exp_q.size() != 0);
        if (pop) check("underflow_pop", fifo_empty_i, 0);
        if (take) begin
            check("sb_nonempty", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) check("sb_data", d, exp_q.pop_front());
        end
        if (pop) begin
            exp_q.push_back(fifo_rdata_i);
            cnt_exp++;
            pops++;
        end
        if (fl) exp_q.delete();
        @(posedge clk);
        if (pop && fifo_q.size() != 0) void'(fifo_q.pop_front());
        @(negedge clk);
        drive_fifo();
        #1;
        check("pop_cnt", pop_cnt_o, cnt_exp);
    endtask

    task automatic enter_reset();
        @(negedge clk);
        rst_n = 1'b0;
        fifo_q.delete();
        exp_q.delete();
        cnt_exp = '0;
        drive_fifo();
        #1;
    endtask

    initial begin
        int p0;
        logic [CW-1:0] prev;
        logic wrap_seen;

        // Reset with data already waiting in the FIFO
        fifo_q = '{8'h11, 8'h22, 8'h33};
        m_ready_i = 1'b1;
        drive_fifo();
        #1;
        check("rst_rden", fifo_rden_o, 0);
        check("rst_valid", m_valid_o, 0);
        check("rst_cnt", pop_cnt_o, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("first_pop_after_release", fifo_rden_o, 1);

        // Streaming at full rate
        cycle();
        check("stream_d0", m_data_o, 8'h11);
        cycle();
        check("stream_d1", m_data_o, 8'h22);
        cycle();
        check("stream_d2", m_data_o, 8'h33);
        cycle();
        check("stream_drained", m_valid_o, 0);
        check("stream_cnt", pop_cnt_o, 3);

        // Backpressure: buffer fills to two, then drains without gaps
        m_ready_i = 1'b0;
        fifo_q = '{8'h11, 8'h22, 8'h33};
        p0 = pops;
        repeat (4) cycle();
        check("bp_pops", pops - p0, 2);
        check("bp_rden_off", fifo_rden_o, 0);
        check("bp_hold", m_data_o, 8'h11);
        m_ready_i = 1'b1;
        check("bp_v0", m_valid_o, 1);
        check("bp_d0", m_data_o, 8'h11);
        cycle();
        check("bp_v1", m_valid_o, 1);
        check("bp_d1", m_data_o, 8'h22);
        cycle();
        check("bp_v2", m_valid_o, 1);
        check("bp_d2", m_data_o, 8'h33);
        cycle();
        check("bp_done", m_valid_o, 0);

        // Flush from TWO with a word left in the FIFO
        m_ready_i = 1'b0;
        fifo_q = '{8'hA0, 8'hA1, 8'hA2};
        cycle();
        cycle();
        p0 = int'(pop_cnt_o);
        flush_i = 1'b1;
        drive_fifo();
        #1;
        check("flush_two_no_pop", fifo_rden_o, 0);
        cycle();
        flush_i = 1'b0;
        check("flush_two_valid", m_valid_o, 0);
        check("flush_two_cnt", pop_cnt_o, p0);
        m_ready_i = 1'b1;
        cycle();
        check("flush_next_word", m_data_o, 8'hA2);
        cycle();

        // Flush in ONE must also block a pop the FIFO could otherwise serve
        m_ready_i = 1'b0;
        fifo_q = '{8'hB0, 8'hB1};
        cycle();
        flush_i = 1'b1;
        drive_fifo();
        #1;
        check("flush_one_no_pop", fifo_rden_o, 0);
        cycle();
        flush_i = 1'b0;
        check("flush_one_valid", m_valid_o, 0);
        m_ready_i = 1'b1;
        cycle();
        check("flush_one_next", m_data_o, 8'hB1);
        cycle();

        // Async reset with words buffered, then counter wrap over 17 pops
        m_ready_i = 1'b0;
        fifo_q = '{8'hC0, 8'hC1, 8'hC2};
        cycle();
        cycle();
        enter_reset();
        check("midrst_valid", m_valid_o, 0);
        check("midrst_cnt", pop_cnt_o, 0);
        for (int i = 0; i < 17; i++) fifo_q.push_back(DW'(i + 8'h40));
        @(negedge clk);
        rst_n = 1'b1;
        m_ready_i = 1'b1;
        wrap_seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            prev = pop_cnt_o;
            cycle();
            if (prev == 4'hF && pop_cnt_o == 4'h0) wrap_seen = 1'b1;
        end
        check("cnt_wrap_seen", wrap_seen, 1);
        check("cnt_final", pop_cnt_o, 1);

        // Random stress
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 2) != 0 && fifo_q.size() < 6) fifo_q.push_back(DW'($urandom));
            gate      = ($urandom_range(0, 3) == 0);
            m_ready_i = ($urandom_range(0, 2) != 0);
            flush_i   = ($urandom_range(0, 49) == 0);
            cycle();
        end
        gate = 1'b0;
        flush_i = 1'b0;
        m_ready_i = 1'b1;
        repeat (20) cycle();
        check("stress_sb_empty", exp_q.size(), 0);
        check("stress_fifo_empty", fifo_q.size(), 0);
        check("stress_valid_low", m_valid_o, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
